// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package pc_fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          INST_W       = 32;
  localparam int          QUEUE_DEPTH  = 2;

  // One buffered fetch result: the instruction word and the address it came from.
  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched instructions until decode accepts them.
// Flush wins over a same-cycle push, so a response that lands on a redirect
// cycle is dropped. Pointers are single bits because the depth is two.
module fetch_queue
  import pc_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] occupancy,
  output logic       empty,
  output entry_t     head
);

  localparam logic [1:0] DEPTH_CNT = 2'(QUEUE_DEPTH);

  entry_t     mem [QUEUE_DEPTH];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_pop    = pop & (count != 2'd0);
  assign do_push   = push & ((count != DEPTH_CNT) | do_pop);
  assign occupancy = count;
  assign empty     = (count == 2'd0);
  assign head      = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues requests to instruction
// memory under a two-credit budget, buffers responses and redirects on a
// taken branch or jump accepted by decode.
// Optional build macro PC_FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// raises fetch_misalign/misalign_addr and freezes fetch until an aligned jump.
//
// Response addresses are not stored per request. Live responses always come
// from one contiguous run ending at fetch_pc-4, so when no kills remain the
// oldest in-flight address is fetch_pc - 4*outstanding.
//
// A request that is still waiting for imem_req_ready when a redirect happens
// keeps its address ("stale"); it completes later, is counted in kill_cnt,
// and does not advance fetch_pc.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_true,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] stale_addr;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [1:0]      outstanding;
  logic [1:0]      kill_cnt;
  logic [1:0]      out_next;
  logic [1:0]      kill_next;
  logic [1:0]      occupancy;
  logic [2:0]      credit_sum;
  logic            run;
  logic            pending;
  logic            stale;
  logic            frozen;
  logic            q_empty;
  logic            req_fire;
  logic            req_stall;
  logic            accept;
  logic            redirect;
  logic            push;
  entry_t          head;
  entry_t          rsp_entry;

  assign credit_sum     = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req_valid = run & (pending | ((credit_sum < 3'd2) & ~frozen));
  assign imem_req_addr  = stale ? stale_addr : fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign req_stall      = imem_req_valid & ~imem_req_ready;

  assign inst_valid = ~q_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign accept     = inst_valid & inst_ready;

  assign target_raw = jump ? jump_target : branch_target;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic trap_redirect;
  logic target_misaligned;

  // While frozen the queue is empty, so the only way out is an aligned jump.
  assign trap_redirect     = frozen & jump & (jump_target[1:0] == 2'b00);
  assign redirect          = (accept & (jump | branch_true)) | trap_redirect;
  assign target            = target_raw;
  assign target_misaligned = (target[1:0] != 2'b00);
`else
  assign frozen   = 1'b0;
  assign redirect = accept & (jump | branch_true);
  assign target   = target_raw & ~(XLEN'(3));
`endif

  assign push          = imem_rsp_valid & (kill_cnt == 2'd0);
  assign rsp_entry.inst = imem_rsp_data;
  assign rsp_entry.pc   = fetch_pc - (XLEN'(outstanding) << 2);

  // Credit and kill bookkeeping for the next cycle.
  always_comb begin
    out_next  = outstanding + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
    kill_next = kill_cnt;
    if (redirect) begin
      kill_next = out_next + {1'b0, req_stall};
    end else if (imem_rsp_valid && (kill_cnt != 2'd0)) begin
      kill_next = kill_cnt - 2'd1;
    end
  end

  // PC, in-flight counters and the held-request tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      kill_cnt    <= 2'd0;
      pending     <= 1'b0;
      stale       <= 1'b0;
      stale_addr  <= RESET_PC;
    end else begin
      run         <= 1'b1;
      outstanding <= out_next;
      kill_cnt    <= kill_next;
      pending     <= req_stall;
      if (redirect) begin
        fetch_pc   <= target;
        stale      <= req_stall;
        stale_addr <= imem_req_addr;
      end else if (req_fire) begin
        stale <= 1'b0;
        if (!stale) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
      end
    end
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  // Misalignment report and fetch freeze, released by the next redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frozen         <= 1'b0;
      fetch_misalign <= 1'b0;
      misalign_addr  <= '0;
    end else begin
      fetch_misalign <= redirect & target_misaligned;
      if (redirect) begin
        frozen <= target_misaligned;
        if (target_misaligned) begin
          misalign_addr <= target;
        end
      end
    end
  end
`endif

  fetch_queue #(
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (rsp_entry),
    .pop        (accept),
    .flush      (redirect),
    .occupancy  (occupancy),
    .empty      (q_empty),
    .head       (head)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with an expected-PC scoreboard and a
// one-cycle-latency instruction memory model.
module tb_pc_fetch;

  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] DKEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_true;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
  logic [31:0] misalign_addr;
`endif

  always #5 clk = ~clk;

  pc_fetch #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_true    (branch_true),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign),
    .misalign_addr  (misalign_addr)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          pop_count = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ DKEY;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: a request accepted at an edge answers during the following cycle.
  initial begin
    logic        acc;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = acc;
      imem_rsp_data  = acc ? mem_word(a) : 32'h0;
    end
  end

  // Scoreboard monitor: every decode accept must match the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst: got pc %08h want no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst", inst, mem_word(e));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    branch_true    = 1'b0;
    jump           = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic consume_to(input int target, input string name);
    int cyc = 0;
    while (pop_count < target && cyc < 200) begin
      tick();
      cyc++;
    end
    inst_ready = 1'b0;
    checks++;
    if (pop_count < target) begin
      failures++;
      $display("FAIL %s: got %0d accepts want %0d", name, pop_count, target);
    end
  endtask

  task automatic wait_head(input logic [31:0] pc);
    int cyc = 0;
    while (!(inst_valid && inst_pc == pc) && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (!(inst_valid && inst_pc == pc)) begin
      failures++;
      $display("FAIL wait_head: got head pc %08h want %08h", inst_pc, pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t want completion", $time);
    $fatal(1);
  end

  initial begin
    int mark;
    rst_n          = 1'b0;
    branch_true    = 1'b0;
    branch_target  = '0;
    jump           = 1'b0;
    jump_target    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;

    // Reset values, then first request one cycle after release.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_req_addr", imem_req_addr, RPC);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("req_valid_release_cycle", imem_req_valid, 0);
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, RPC);

    // Streaming.
    mark = pop_count;
    for (int i = 0; i < 4; i++) exp_q.push_back(RPC + 32'(4 * i));
    tick();
    inst_ready = 1'b1;
    consume_to(mark + 4, "stream");

    // Backpressure: queue fills and requests stop, then order resumes.
    repeat (6) tick();
    @(negedge clk);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_inst_valid", inst_valid, 1);
    mark = pop_count;
    for (int i = 4; i < 8; i++) exp_q.push_back(RPC + 32'(4 * i));
    tick();
    inst_ready = 1'b1;
    consume_to(mark + 4, "bp_resume");

    // Taken branch while the next sequential fetch is in flight.
    do_reset();
    mark = pop_count;
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'h4);
    exp_q.push_back(RPC + 32'h100);
    exp_q.push_back(RPC + 32'h104);
    inst_ready = 1'b1;
    wait_head(RPC + 32'h4);
    branch_true   = 1'b1;
    branch_target = RPC + 32'h100;
    tick();
    branch_true = 1'b0;
    consume_to(mark + 4, "branch");

    // Jump has priority over a simultaneous branch.
    do_reset();
    mark = pop_count;
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'h4);
    exp_q.push_back(RPC + 32'h200);
    exp_q.push_back(RPC + 32'h204);
    inst_ready = 1'b1;
    wait_head(RPC + 32'h4);
    jump          = 1'b1;
    jump_target   = RPC + 32'h200;
    branch_true   = 1'b1;
    branch_target = RPC + 32'h300;
    tick();
    jump        = 1'b0;
    branch_true = 1'b0;
    consume_to(mark + 4, "priority");

    // Held request across a redirect keeps its address and is killed.
    do_reset();
    mark = pop_count;
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'h4);
    exp_q.push_back(RPC + 32'h400);
    exp_q.push_back(RPC + 32'h404);
    inst_ready = 1'b1;
    wait_head(RPC + 32'h4);
    branch_true    = 1'b1;
    branch_target  = RPC + 32'h400;
    imem_req_ready = 1'b0;
    tick();
    branch_true = 1'b0;
    @(negedge clk);
    check("held_valid_1", imem_req_valid, 1);
    check("held_addr_1", imem_req_addr, RPC + 32'h8);
    tick();
    @(negedge clk);
    check("held_valid_2", imem_req_valid, 1);
    check("held_addr_2", imem_req_addr, RPC + 32'h8);
    tick();
    imem_req_ready = 1'b1;
    consume_to(mark + 4, "held_redirect");

`ifndef PC_FETCH_MISALIGN_TRAP_EN
    // Target low bits are dropped.
    do_reset();
    mark = pop_count;
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'h4);
    exp_q.push_back(RPC + 32'h500);
    exp_q.push_back(RPC + 32'h504);
    inst_ready = 1'b1;
    wait_head(RPC + 32'h4);
    branch_true   = 1'b1;
    branch_target = RPC + 32'h503;
    tick();
    branch_true = 1'b0;
    consume_to(mark + 4, "truncate");
`else
    // Misaligned jump traps and freezes fetch until an aligned jump.
    do_reset();
    mark = pop_count;
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'h4);
    exp_q.push_back(RPC + 32'h200);
    exp_q.push_back(RPC + 32'h204);
    inst_ready = 1'b1;
    wait_head(RPC + 32'h4);
    jump        = 1'b1;
    jump_target = RPC + 32'h102;
    tick();
    jump = 1'b0;
    @(negedge clk);
    check("misalign_pulse", fetch_misalign, 1);
    check("misalign_addr", misalign_addr, RPC + 32'h102);
    check("frozen_req_valid_0", imem_req_valid, 0);
    tick();
    @(negedge clk);
    check("misalign_pulse_end", fetch_misalign, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("frozen_req_valid", imem_req_valid, 0);
    end
    tick();
    inst_ready  = 1'b1;
    jump        = 1'b1;
    jump_target = RPC + 32'h200;
    tick();
    jump = 1'b0;
    consume_to(mark + 4, "trap_resume");
`endif

    check("scoreboard_left", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
